// File: rtl/cnn_stream_loader_pkg.sv
// Shared definitions for the CNN stream loader: default geometry,
// loader FSM states and address-width helper.
package cnn_stream_loader_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 16;
  localparam int unsigned DEF_IMG_WIDTH   = 4;
  localparam int unsigned DEF_IMG_HEIGHT  = 4;
  localparam int unsigned DEF_NUM_FILTERS = 2;
  localparam int unsigned TAPS_PER_FILTER = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_IMG,
    ST_LOAD_W,
    ST_START,
    ST_WAIT_DONE,
    ST_DRAIN
  } loader_state_e;

  // Address width for a memory of n words; never narrower than one bit.
  function automatic int unsigned addr_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_beat_counter.sv
// Wrap-to-zero beat counter with synchronous clear and a terminal-count flag.
module cnn_beat_counter
  import cnn_stream_loader_pkg::*;
#(
  parameter int unsigned COUNT = 16,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  assign at_max = (count == WIDTH'(COUNT - 1));

  // Clear has priority over increment; the last value wraps back to zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= at_max ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cnn_stream_loader.sv
// Streaming front-end for conv_core: writes an image frame (and optionally
// filter weights) into the core memories, then starts the core and waits.
module cnn_stream_loader
  import cnn_stream_loader_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter  int unsigned IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter  int unsigned IMG_HEIGHT  = DEF_IMG_HEIGHT,
  parameter  int unsigned NUM_FILTERS = DEF_NUM_FILTERS,
  localparam int unsigned IMG_SIZE    = IMG_WIDTH * IMG_HEIGHT,
  localparam int unsigned W_SIZE      = NUM_FILTERS * TAPS_PER_FILTER,
  localparam int unsigned IMG_AW      = addr_bits(IMG_SIZE),
  localparam int unsigned W_AW        = addr_bits(W_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  cfg_load_w,
  output logic                  img_we,
  output logic [IMG_AW-1:0]     img_addr,
  output logic [DATA_WIDTH-1:0] img_wdata,
  output logic                  w_we,
  output logic [W_AW-1:0]       w_addr,
  output logic [DATA_WIDTH-1:0] w_wdata,
  output logic                  core_start,
  input  logic                  core_done,
  output logic                  busy,
  output logic                  frame_err
);

  loader_state_e state_q, state_d;
  logic          wmode_q;
  logic          wmode_eff;
  logic          beat;
  logic          img_wr, w_wr, err;
  logic          cnt_clear;
  logic          pix_en, w_en;
  logic          pix_at_max, w_at_max;
  logic [IMG_AW-1:0] pix_cnt;
  logic [W_AW-1:0]   w_cnt;

  assign beat      = s_valid && s_ready;
  // The first beat of a frame is accepted in IDLE, before wmode is stored.
  assign wmode_eff = (state_q == ST_IDLE) ? cfg_load_w : wmode_q;
  assign cnt_clear = (state_d == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

  cnn_beat_counter #(
    .COUNT (IMG_SIZE),
    .WIDTH (IMG_AW)
  ) u_pix_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .en     (pix_en),
    .count  (pix_cnt),
    .at_max (pix_at_max)
  );

  cnn_beat_counter #(
    .COUNT (W_SIZE),
    .WIDTH (W_AW)
  ) u_w_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .en     (w_en),
    .count  (w_cnt),
    .at_max (w_at_max)
  );

  // Next-state, write-strobe and framing-error decode.
  always_comb begin
    state_d = state_q;
    img_wr  = 1'b0;
    w_wr    = 1'b0;
    err     = 1'b0;
    pix_en  = 1'b0;
    w_en    = 1'b0;
    unique case (state_q)
      // IDLE and LOAD_IMG share the image path; IDLE's pix_cnt is always 0.
      ST_IDLE, ST_LOAD_IMG: begin
        if (beat) begin
          img_wr = 1'b1;
          pix_en = 1'b1;
          if (pix_at_max) begin
            if (!wmode_eff) begin
              if (s_last) begin
                state_d = ST_START;
              end else begin
                err     = 1'b1;
                state_d = ST_DRAIN;
              end
            end else if (s_last) begin
              err     = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_LOAD_W;
            end
          end else if (s_last) begin
            err     = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOAD_IMG;
          end
        end
      end
      ST_LOAD_W: begin
        if (beat) begin
          w_wr = 1'b1;
          w_en = 1'b1;
          if (w_at_max) begin
            if (s_last) begin
              state_d = ST_START;
            end else begin
              err     = 1'b1;
              state_d = ST_DRAIN;
            end
          end else if (s_last) begin
            err     = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_START: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (core_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (beat && s_last) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register, frame mode, registered ready and write/control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wmode_q    <= 1'b0;
      s_ready    <= 1'b0;
      img_we     <= 1'b0;
      img_addr   <= '0;
      img_wdata  <= '0;
      w_we       <= 1'b0;
      w_addr     <= '0;
      w_wdata    <= '0;
      core_start <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && beat) begin
        wmode_q <= cfg_load_w;
      end
      // Ready is decoded from the next state so it is a plain flop output.
      s_ready <= (state_d == ST_IDLE) || (state_d == ST_LOAD_IMG) ||
                 (state_d == ST_LOAD_W) || (state_d == ST_DRAIN);
      img_we <= img_wr;
      if (img_wr) begin
        img_addr  <= pix_cnt;
        img_wdata <= s_data;
      end
      w_we <= w_wr;
      if (w_wr) begin
        w_addr  <= w_cnt;
        w_wdata <= s_data;
      end
      // START lasts one cycle, so this lands right after the final write.
      core_start <= (state_q == ST_START);
      frame_err  <= err;
    end
  end

endmodule

// File: tb/tb_cnn_stream_loader.sv
// Self-checking bench for cnn_stream_loader: table-driven frames from the
// test plan, hand-written reset sequences, and randomized frames checked
// against a transaction-level reference model.
module tb_cnn_stream_loader;

  localparam int DW  = 16;
  localparam int ISZ = 16;
  localparam int WSZ = 18;

  logic          clk = 1'b0;
  logic          reset, s_valid, s_ready, s_last, cfg_load_w;
  logic          img_we, w_we, core_start, core_done, busy, frame_err;
  logic [DW-1:0] s_data, img_wdata, w_wdata;
  logic [3:0]    img_addr;
  logic [4:0]    w_addr;

  always #5 clk = ~clk;

  cnn_stream_loader #(
    .DATA_WIDTH  (16),
    .IMG_WIDTH   (4),
    .IMG_HEIGHT  (4),
    .NUM_FILTERS (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .cfg_load_w (cfg_load_w),
    .img_we     (img_we),
    .img_addr   (img_addr),
    .img_wdata  (img_wdata),
    .w_we       (w_we),
    .w_addr     (w_addr),
    .w_wdata    (w_wdata),
    .core_start (core_start),
    .core_done  (core_done),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Observed transactions
  int img_a[$], img_d[$], w_a[$], w_d[$];
  int n_start, n_err, both_we, last_we_cyc, start_cyc;

  // Expected transactions from the reference model
  int exp_img_a[$], exp_img_d[$], exp_w_a[$], exp_w_d[$];
  int exp_err, exp_start;

  logic [DW-1:0] words[$];

  typedef struct {
    bit lw;
    int n;
    int last_idx;
    bit gaps;
    int nimg;
    int nw;
    int nerr;
    int nstart;
    int delay;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: advance past the edge, then record what the DUT drove.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (img_we) begin
      img_a.push_back(int'(img_addr));
      img_d.push_back(int'(img_wdata));
      last_we_cyc = cyc;
    end
    if (w_we) begin
      w_a.push_back(int'(w_addr));
      w_d.push_back(int'(w_wdata));
      last_we_cyc = cyc;
    end
    if (img_we && w_we) both_we++;
    if (core_start) begin
      n_start++;
      start_cyc = cyc;
    end
    if (frame_err) n_err++;
  endtask

  task automatic clear_log();
    img_a.delete(); img_d.delete(); w_a.delete(); w_d.delete();
    n_start = 0; n_err = 0; both_we = 0; last_we_cyc = -100; start_cyc = -100;
  endtask

  // Reference: walk the accepted words of one frame by the framing rules.
  task automatic model(input bit lw, input int n, input int last_idx);
    int  total;
    bit  loading;
    exp_img_a.delete(); exp_img_d.delete(); exp_w_a.delete(); exp_w_d.delete();
    exp_err = 0; exp_start = 0;
    total   = ISZ + (lw ? WSZ : 0);
    loading = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (loading) begin
        if (i < ISZ) begin
          exp_img_a.push_back(i); exp_img_d.push_back(int'(words[i]));
        end else begin
          exp_w_a.push_back(i - ISZ); exp_w_d.push_back(int'(words[i]));
        end
        if (i == total - 1) begin
          loading = 1'b0;
          if (i == last_idx) begin
            exp_start = 1;
            break;
          end
          exp_err = 1;
        end else if (i == last_idx) begin
          exp_err = 1;
          break;
        end
      end else if (i == last_idx) begin
        break;
      end
    end
  endtask

  task automatic send(input bit lw, input int n, input int last_idx, input bit gaps);
    int i = 0;
    int guard = 0;
    bit v, rdy;
    while (i < n && guard < n * 8 + 50) begin
      v          = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_valid    = v;
      s_data     = words[i];
      s_last     = (i == last_idx);
      cfg_load_w = (i == 0) ? lw : 1'($urandom_range(0, 1));
      core_done  = ($urandom_range(0, 7) == 0);
      rdy        = s_ready;
      tick();
      if (v && rdy) i++;
      guard++;
    end
    s_valid = 1'b0; s_last = 1'b0; core_done = 1'b0;
    if (i < n) chk("send_timeout", i, n);
  endtask

  task automatic finish_frame(input int delay);
    int viol = 0;
    if (exp_start != 0) begin
      for (int t = 0; t < 10 && n_start == 0; t++) tick();
      chk("start_seen", n_start, 1);
      chk("start_timing", start_cyc, last_we_cyc + 1);
      for (int d = 0; d < delay; d++) begin
        if (s_ready !== 1'b0 || busy !== 1'b1) viol++;
        tick();
      end
      chk("ready_low_wait", viol, 0);
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
    end
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_ready", s_ready, 1);
    // A stray done while idle must be ignored.
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    chk("idle_after_done", busy, 0);
  endtask

  task automatic compare_logs();
    chk("img_count", img_a.size(), exp_img_a.size());
    chk("w_count", w_a.size(), exp_w_a.size());
    for (int i = 0; i < img_a.size() && i < exp_img_a.size(); i++) begin
      chk("img_addr", img_a[i], exp_img_a[i]);
      chk("img_data", img_d[i], exp_img_d[i]);
    end
    for (int i = 0; i < w_a.size() && i < exp_w_a.size(); i++) begin
      chk("w_addr", w_a[i], exp_w_a[i]);
      chk("w_data", w_d[i], exp_w_d[i]);
    end
    chk("frame_err_count", n_err, exp_err);
    chk("start_count", n_start, exp_start);
    chk("both_we", both_we, 0);
  endtask

  task automatic run_frame(input bit lw, input int n, input int last_idx, input bit gaps,
                           input int delay);
    clear_log();
    model(lw, n, last_idx);
    send(lw, n, last_idx, gaps);
    finish_frame(delay);
    compare_logs();
  endtask

  task automatic plan_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++)
      words.push_back((i < ISZ) ? 16'(16'h0100 + i) : 16'(16'hFF00 + (i - ISZ)));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_img_we"}, img_we, 0);
    chk({tag, "_w_we"}, w_we, 0);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_img_addr"}, img_addr, 0);
    chk({tag, "_img_wdata"}, img_wdata, 0);
    chk({tag, "_w_addr"}, w_addr, 0);
    chk({tag, "_w_wdata"}, w_wdata, 0);
  endtask

  initial begin
    // lw, n, last_idx, gaps, nimg, nw, nerr, nstart, done delay
    tbl[0] = '{1'b0, 16, 15, 1'b0, 16,  0, 0, 1,  3};  // image only
    tbl[1] = '{1'b1, 34, 33, 1'b0, 16, 18, 0, 1,  3};  // image + weights
    tbl[2] = '{1'b1, 34, 33, 1'b1, 16, 18, 0, 1, 50};  // backpressure
    tbl[3] = '{1'b0, 10,  9, 1'b0, 10,  0, 1, 0,  0};  // early last
    tbl[4] = '{1'b0, 19, 18, 1'b0, 16,  0, 1, 0,  0};  // missing last
    tbl[5] = '{1'b1, 20, 19, 1'b0, 16,  4, 1, 0,  0};  // early last in weights
    tbl[6] = '{1'b1,  1,  0, 1'b0,  1,  0, 1, 0,  0};  // single-word frame
    tbl[7] = '{1'b1, 36, 35, 1'b1, 16, 18, 1, 0,  0};  // missing last in weights

    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    cfg_load_w = 1'b0; core_done = 1'b0;
    clear_log();
    tick();
    check_reset_outputs("rst");
    tick();
    reset = 1'b0;
    tick();
    chk("post_reset_ready", s_ready, 1);
    chk("post_reset_busy", busy, 0);

    for (int k = 0; k < 8; k++) begin
      plan_words(tbl[k].n);
      run_frame(tbl[k].lw, tbl[k].n, tbl[k].last_idx, tbl[k].gaps, tbl[k].delay);
      chk("tbl_nimg", img_a.size(), tbl[k].nimg);
      chk("tbl_nw", w_a.size(), tbl[k].nw);
      chk("tbl_nerr", n_err, tbl[k].nerr);
      chk("tbl_nstart", n_start, tbl[k].nstart);
    end

    // Reset in the middle of an image load: abandoned, no start.
    plan_words(16);
    clear_log();
    send(1'b0, 8, -1, 1'b0);
    chk("abort_writes", img_a.size(), 8);
    reset = 1'b1;
    tick();
    check_reset_outputs("mid_rst");
    tick();
    reset = 1'b0;
    tick();
    for (int t = 0; t < 4; t++) tick();
    chk("abort_no_start", n_start, 0);
    chk("abort_busy", busy, 0);
    run_frame(1'b0, 16, 15, 1'b0, 3);
    chk("after_abort_first_addr", (img_a.size() > 0) ? img_a[0] : -1, 0);

    // Randomized frames of every framing kind.
    for (int r = 0; r < 24; r++) begin
      bit lw;
      int kind, total, n, last_idx;
      lw    = 1'($urandom_range(0, 1));
      kind  = $urandom_range(0, 2);
      total = ISZ + (lw ? WSZ : 0);
      if (kind == 0) begin
        n = total; last_idx = total - 1;
      end else if (kind == 1) begin
        last_idx = $urandom_range(0, total - 2); n = last_idx + 1;
      end else begin
        n = total + $urandom_range(1, 3); last_idx = n - 1;
      end
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(16'($urandom));
      run_frame(lw, n, last_idx, 1'b1, $urandom_range(0, 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
